trk_lock_ctrl: RTL and testbench
================================

// Module: trk_lock_ctrl
// PURPOSE
//  Sequences one B1 BOC tracking channel: requests acquisition and holds the tracking loop in reset.
//  Releases tracking reset on the clock where the local PRN phase matches the acquired code phase.
//  Masks lock decisions during pull-in, then runs a prompt-I/Q lock detector every PRN epoch.
//  On loss of lock it re-asserts tracking reset and re-requests acquisition.
// PARAMETERS
//  PRN_PHS_WIDTH  12      width of PRN code-phase index
//  ACC_WIDTH      24      width of signed prompt accumulations
//  PULLIN_EPOCHS  200     epochs in PULLIN before lock detection starts (>=1)
//  LOCK_MAX       63      saturation value of lock up/down counter
//  LOCK_ON        40      counter value at/above which tx_trk_lock asserts (1..LOCK_MAX)
//  ALIGN_TMO      65535   rx_clk cycles allowed in ALIGN before abort (>=1)
// PORTS
//  rx_clk        in   1              system clock
//  rx_rst        in   1              synchronous active-high reset
//  rx_thr        in   ACC_WIDTH      unsigned |I| lock threshold, sampled at each rx_prn_sop
//  rx_acq_suc    in   1              acquisition success pulse
//  rx_acq_phs    in   PRN_PHS_WIDTH  acquired code phase, valid with rx_acq_suc
//  rx_prn_phs    in   PRN_PHS_WIDTH  current phase of the tracking PRN generator
//  rx_prn_sop    in   1              PRN epoch start strobe; prompt accumulations valid this cycle
//  rx_acc_pi     in   ACC_WIDTH      signed prompt I accumulation of the last epoch
//  rx_acc_pq     in   ACC_WIDTH      signed prompt Q accumulation of the last epoch
//  tx_trk_rst    out  1              reset to tracking datapath/LPF
//  tx_acq_start  out  1              level request to the acquisition engine
//  tx_trk_lock   out  1              channel locked
//  tx_state      out  3              FSM state code, for debug
// BEHAVIOUR
//  Reset values: tx_trk_rst=1, tx_acq_start=0, tx_trk_lock=0, tx_state=IDLE(0).
//   All counters are 0 and the latched phase is 0.
//  All outputs are registered.
//  State codes: IDLE=0, ACQ=1, ALIGN=2, PULLIN=3, TRACK=4.
//  IDLE: go to ACQ on the next clock.
//  ACQ: tx_acq_start=1, tx_trk_rst=1.
//   On rx_acq_suc, latch rx_acq_phs, clear the timeout counter, and go to ALIGN.
//  ALIGN: tx_acq_start=0, tx_trk_rst=1, timeout counter increments every cycle.
//   If rx_prn_phs==latched phase: go to PULLIN, and tx_trk_rst=0 from the next cycle.
//   Else if the counter reaches ALIGN_TMO-1: go to ACQ.
//   A phase match on the timeout cycle wins.
//  PULLIN: tx_trk_rst=0. Count rx_prn_sop strobes.
//   On the PULLIN_EPOCHS-th strobe, go to TRACK with lock_cnt=0.
//  TRACK: on each rx_prn_sop, compute aI=|rx_acc_pi| and aQ=|rx_acc_pq|.
//   abs() of the most-negative value saturates to the max positive value.
//   good = (aI>=rx_thr) && (aI>aQ).
//   good: lock_cnt+1, saturating at LOCK_MAX. Otherwise: lock_cnt-1.
//   tx_trk_lock is registered and updates the cycle after the sop: 1 when lock_cnt>=LOCK_ON, else 0.
//   Bad epoch with lock_cnt==0: go to ACQ and clear tx_trk_lock.
//    tx_trk_rst=1 and tx_acq_start=1 from the next cycle.
//  rx_acq_suc outside ACQ is ignored.
//  rx_prn_sop outside PULLIN/TRACK is ignored.
//  rx_rst in any state returns all registers to reset values on the next clock.
//  Latency: rx_prn_sop -> tx_trk_lock/state update is 1 cycle.
//   ALIGN match -> tx_trk_rst low is 1 cycle.
// TESTING
//  1. Reset, acq_suc with phs=0x123, rx_prn_phs ramps 0..: tx_trk_rst falls 1 clk after phs==0x123.
//     tx_state goes 2->3.
//  2. PULLIN_EPOCHS=4, pi=+5000, pq=100, thr=1000: TRACK after 4 sops.
//     tx_trk_lock rises 1 clk after the 40th TRACK sop.
//  3. Locked (lock_cnt=63), then pi=0 for every sop: tx_trk_lock falls when lock_cnt drops to 39.
//     Back to ACQ, tx_acq_start=1, on the 64th bad sop.
//  4. ALIGN_TMO=16 with rx_prn_phs never matching: state returns to ACQ after 16 clks.
//     Match on clk 16: PULLIN.
//  5. pi=0x800000, pq=0, thr=0x7FFFFF: counted good, since abs saturates.
//  6. rx_rst asserted mid-TRACK while locked: next clk tx_trk_rst=1, tx_trk_lock=0, state IDLE.

Source files
------------

// File: rtl/trk_lock_ctrl.sv
// -----------------------------------------------------------------------------
// trk_lock_ctrl
//
// Sequencer for one B1 BOC tracking channel.
//  - Requests acquisition and holds the tracking datapath in reset until the
//    acquisition engine reports a code phase.
//  - Releases tracking reset on the clock where the local PRN generator phase
//    equals the acquired phase (or gives up after ALIGN_TMO cycles).
//  - Ignores lock decisions for PULLIN_EPOCHS epochs while the loops settle.
//  - Runs a prompt I/Q up/down lock detector once per PRN epoch. When the
//    counter is already empty and another bad epoch arrives, the channel drops
//    back to acquisition.
//
// Ports
//  rx_clk        in   system clock
//  rx_rst        in   synchronous active-high reset
//  rx_thr        in   unsigned |I| lock threshold, sampled with rx_prn_sop
//  rx_acq_suc    in   acquisition success pulse
//  rx_acq_phs    in   acquired code phase, valid with rx_acq_suc
//  rx_prn_phs    in   current phase of the tracking PRN generator
//  rx_prn_sop    in   PRN epoch start; prompt accumulations valid this cycle
//  rx_acc_pi     in   signed prompt I accumulation of the last epoch
//  rx_acc_pq     in   signed prompt Q accumulation of the last epoch
//  tx_trk_rst    out  reset to tracking datapath / loop filter
//  tx_acq_start  out  level request to the acquisition engine
//  tx_trk_lock   out  channel locked
//  tx_state      out  FSM state code (IDLE=0 ACQ=1 ALIGN=2 PULLIN=3 TRACK=4)
//
// All outputs are registered. The output flops are loaded from the decode of
// the next state, so they change on the same edge as tx_state.
// -----------------------------------------------------------------------------
module trk_lock_ctrl #(
    parameter int PRN_PHS_WIDTH = 12,
    parameter int ACC_WIDTH     = 24,
    parameter int PULLIN_EPOCHS = 200,
    parameter int LOCK_MAX      = 63,
    parameter int LOCK_ON       = 40,
    parameter int ALIGN_TMO     = 65535
) (
    input  logic                     rx_clk,
    input  logic                     rx_rst,
    input  logic [ACC_WIDTH-1:0]     rx_thr,
    input  logic                     rx_acq_suc,
    input  logic [PRN_PHS_WIDTH-1:0] rx_acq_phs,
    input  logic [PRN_PHS_WIDTH-1:0] rx_prn_phs,
    input  logic                     rx_prn_sop,
    input  logic [ACC_WIDTH-1:0]     rx_acc_pi,
    input  logic [ACC_WIDTH-1:0]     rx_acc_pq,
    output logic                     tx_trk_rst,
    output logic                     tx_acq_start,
    output logic                     tx_trk_lock,
    output logic [2:0]               tx_state
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ACQ    = 3'd1,
        ST_ALIGN  = 3'd2,
        ST_PULLIN = 3'd3,
        ST_TRACK  = 3'd4
    } state_t;

    // Counter widths: each counter only has to reach its terminal value.
    localparam int TMO_W = (ALIGN_TMO > 1)     ? $clog2(ALIGN_TMO)     : 1;
    localparam int PE_W  = (PULLIN_EPOCHS > 1) ? $clog2(PULLIN_EPOCHS) : 1;
    localparam int LC_W  = $clog2(LOCK_MAX + 1);

    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(ALIGN_TMO - 1);
    localparam logic [PE_W-1:0]  PE_LAST  = PE_W'(PULLIN_EPOCHS - 1);
    localparam logic [LC_W-1:0]  LC_MAX   = LC_W'(LOCK_MAX);
    localparam logic [LC_W-1:0]  LC_ON    = LC_W'(LOCK_ON);

    localparam logic [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};
    localparam logic [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};

    // |v| of a two's complement value. The most negative value has no
    // positive counterpart, so it is clamped to the largest positive one.
    function automatic logic [ACC_WIDTH-1:0] sat_abs(input logic [ACC_WIDTH-1:0] v);
        logic [ACC_WIDTH-1:0] r;
        if (v == ACC_MIN) begin
            r = ACC_MAX;
        end else if (v[ACC_WIDTH-1]) begin
            r = -v;
        end else begin
            r = v;
        end
        return r;
    endfunction

    state_t                   state_q, state_d;
    logic [PRN_PHS_WIDTH-1:0] phs_q, phs_d;
    logic [TMO_W-1:0]         tmo_q, tmo_d;
    logic [PE_W-1:0]          pe_q, pe_d;
    logic [LC_W-1:0]          lc_q, lc_d;
    logic                     trk_rst_q, trk_rst_d;
    logic                     acq_start_q, acq_start_d;
    logic                     lock_q, lock_d;

    logic [ACC_WIDTH-1:0]     abs_i;
    logic [ACC_WIDTH-1:0]     abs_q;
    logic                     epoch_good;

    assign abs_i      = sat_abs(rx_acc_pi);
    assign abs_q      = sat_abs(rx_acc_pq);
    assign epoch_good = (abs_i >= rx_thr) && (abs_i > abs_q);

    always_comb begin
        state_d = state_q;
        phs_d   = phs_q;
        tmo_d   = tmo_q;
        pe_d    = pe_q;
        lc_d    = lc_q;
        lock_d  = lock_q;

        case (state_q)
            ST_IDLE: begin
                state_d = ST_ACQ;
            end

            ST_ACQ: begin
                if (rx_acq_suc) begin
                    phs_d   = rx_acq_phs;
                    tmo_d   = '0;
                    state_d = ST_ALIGN;
                end
            end

            ST_ALIGN: begin
                tmo_d = tmo_q + TMO_W'(1);
                // Phase match is tested first so a match on the last
                // permitted cycle still proceeds to PULLIN.
                if (rx_prn_phs == phs_q) begin
                    pe_d    = '0;
                    state_d = ST_PULLIN;
                end else if (tmo_q == TMO_LAST) begin
                    state_d = ST_ACQ;
                end
            end

            ST_PULLIN: begin
                if (rx_prn_sop) begin
                    if (pe_q == PE_LAST) begin
                        lc_d    = '0;
                        state_d = ST_TRACK;
                    end else begin
                        pe_d = pe_q + PE_W'(1);
                    end
                end
            end

            ST_TRACK: begin
                if (rx_prn_sop) begin
                    if (epoch_good) begin
                        lc_d   = (lc_q == LC_MAX) ? lc_q : lc_q + LC_W'(1);
                        lock_d = (lc_d >= LC_ON);
                    end else if (lc_q == '0) begin
                        // Counter already empty: lock is lost.
                        lock_d  = 1'b0;
                        state_d = ST_ACQ;
                    end else begin
                        lc_d   = lc_q - LC_W'(1);
                        lock_d = (lc_d >= LC_ON);
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Tracking runs only in PULLIN and TRACK; acquisition is requested
        // only while in ACQ.
        trk_rst_d   = !((state_d == ST_PULLIN) || (state_d == ST_TRACK));
        acq_start_d = (state_d == ST_ACQ);
    end

    always_ff @(posedge rx_clk) begin
        if (rx_rst) begin
            state_q     <= ST_IDLE;
            phs_q       <= '0;
            tmo_q       <= '0;
            pe_q        <= '0;
            lc_q        <= '0;
            trk_rst_q   <= 1'b1;
            acq_start_q <= 1'b0;
            lock_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            phs_q       <= phs_d;
            tmo_q       <= tmo_d;
            pe_q        <= pe_d;
            lc_q        <= lc_d;
            trk_rst_q   <= trk_rst_d;
            acq_start_q <= acq_start_d;
            lock_q      <= lock_d;
        end
    end

    assign tx_trk_rst   = trk_rst_q;
    assign tx_acq_start = acq_start_q;
    assign tx_trk_lock  = lock_q;
    assign tx_state     = state_q;

endmodule

// File: tb/tb_trk_lock_ctrl.sv
// -----------------------------------------------------------------------------
// tb_trk_lock_ctrl
//
// Scoreboard bench for trk_lock_ctrl. Every clock, a behavioural reference of
// the channel sequencer predicts the registered outputs from the inputs being
// driven; the prediction is queued and compared once the DUT has clocked.
// Directed scenarios add explicit epoch/cycle counts for the key timings.
// -----------------------------------------------------------------------------
module tb_trk_lock_ctrl;

    localparam int PW   = 12;
    localparam int AW   = 24;
    localparam int PE   = 4;
    localparam int LMAX = 63;
    localparam int LON  = 40;
    localparam int TMO  = 16;

    logic          clk;
    logic          rx_rst;
    logic [AW-1:0] rx_thr;
    logic          rx_acq_suc;
    logic [PW-1:0] rx_acq_phs;
    logic [PW-1:0] rx_prn_phs;
    logic          rx_prn_sop;
    logic [AW-1:0] rx_acc_pi;
    logic [AW-1:0] rx_acc_pq;
    logic          tx_trk_rst;
    logic          tx_acq_start;
    logic          tx_trk_lock;
    logic [2:0]    tx_state;

    trk_lock_ctrl #(
        .PRN_PHS_WIDTH (PW),
        .ACC_WIDTH     (AW),
        .PULLIN_EPOCHS (PE),
        .LOCK_MAX      (LMAX),
        .LOCK_ON       (LON),
        .ALIGN_TMO     (TMO)
    ) dut (
        .rx_clk       (clk),
        .rx_rst       (rx_rst),
        .rx_thr       (rx_thr),
        .rx_acq_suc   (rx_acq_suc),
        .rx_acq_phs   (rx_acq_phs),
        .rx_prn_phs   (rx_prn_phs),
        .rx_prn_sop   (rx_prn_sop),
        .rx_acc_pi    (rx_acc_pi),
        .rx_acc_pq    (rx_acc_pq),
        .tx_trk_rst   (tx_trk_rst),
        .tx_acq_start (tx_acq_start),
        .tx_trk_lock  (tx_trk_lock),
        .tx_state     (tx_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    string tag = "init";

    task automatic check_val(input string name, input longint obs, input longint exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s got %0d expected %0d", name, obs, exp);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct packed {
        logic [2:0] st;
        logic       trk_rst;
        logic       acq;
        logic       lock;
    } exp_t;

    exp_t sb_q[$];

    int m_st  = 0;
    int m_phs = 0;
    int m_tmo = 0;
    int m_pe  = 0;
    int m_lc  = 0;
    bit m_lock = 0;

    function automatic longint mag(input logic [AW-1:0] v);
        longint s;
        s = longint'($signed(v));
        if (s < 0) s = -s;
        if (s > 64'sd8388607) s = 64'sd8388607;
        return s;
    endfunction

    // Advance the model by one clock using the inputs currently driven.
    task automatic model_clock();
        longint ai, aq;
        bit good;
        if (rx_rst) begin
            m_st = 0; m_phs = 0; m_tmo = 0; m_pe = 0; m_lc = 0; m_lock = 0;
        end else begin
            case (m_st)
                0: m_st = 1;
                1: if (rx_acq_suc) begin
                       m_phs = int'(rx_acq_phs);
                       m_tmo = 0;
                       m_st  = 2;
                   end
                2: begin
                       if (int'(rx_prn_phs) == m_phs) begin
                           m_st = 3;
                           m_pe = 0;
                       end else if (m_tmo == TMO - 1) begin
                           m_st = 1;
                       end else begin
                           m_tmo++;
                       end
                   end
                3: if (rx_prn_sop) begin
                       m_pe++;
                       if (m_pe == PE) begin
                           m_st = 4;
                           m_lc = 0;
                       end
                   end
                4: if (rx_prn_sop) begin
                       ai   = mag(rx_acc_pi);
                       aq   = mag(rx_acc_pq);
                       good = (ai >= longint'(rx_thr)) && (ai > aq);
                       if (good)           m_lc = (m_lc < LMAX) ? m_lc + 1 : LMAX;
                       else if (m_lc == 0) m_st = 1;
                       else                m_lc--;
                       m_lock = (m_st == 4) && (m_lc >= LON);
                   end
                default: m_st = 0;
            endcase
        end
    endtask

    // One clock: predict, queue, clock the DUT, pop and compare.
    task automatic tick();
        exp_t e;
        model_clock();
        e.st      = 3'(m_st);
        e.trk_rst = !(m_st == 3 || m_st == 4);
        e.acq     = (m_st == 1);
        e.lock    = m_lock;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        check_val({tag, ".state"},     longint'(tx_state),     longint'(e.st));
        check_val({tag, ".trk_rst"},   longint'(tx_trk_rst),   longint'(e.trk_rst));
        check_val({tag, ".acq_start"}, longint'(tx_acq_start), longint'(e.acq));
        check_val({tag, ".lock"},      longint'(tx_trk_lock),  longint'(e.lock));
    endtask

    task automatic send_sop();
        rx_prn_sop = 1'b1;
        tick();
        rx_prn_sop = 1'b0;
        tick();
    endtask

    // From ACQ: acquire with an immediate phase match, then finish pull-in.
    task automatic enter_track();
        rx_acq_phs = 12'h2A0;
        rx_prn_phs = 12'h2A0;
        rx_acq_suc = 1'b1;
        tick();
        rx_acq_suc = 1'b0;
        tick();
        rx_acc_pi = '0;
        rx_acc_pq = '0;
        for (int i = 0; i < PE; i++) send_sop();
    endtask

    // Good/bad decision table, each applied from lock_cnt == 0.
    typedef struct {
        int pi;
        int pq;
        int thr;
        bit good;
    } tv_t;

    tv_t tbl[5] = '{
        '{-1000,   999, 1000,     1'b1},
        '{ 1000, -1000, 1000,     1'b0},
        '{  999,     0, 1000,     1'b0},
        '{ -5000,  100, 1000,     1'b1},
        '{ 0,        0, 0,        1'b0}
    };

    initial begin
        int n;
        rx_rst     = 1'b1;
        rx_thr     = '0;
        rx_acq_suc = 1'b0;
        rx_acq_phs = '0;
        rx_prn_phs = '0;
        rx_prn_sop = 1'b0;
        rx_acc_pi  = '0;
        rx_acc_pq  = '0;

        // Reset state
        tag = "reset";
        repeat (3) tick();
        rx_rst = 1'b0;

        // 1. Acquire at 0x123, PRN phase ramps into it.
        tag = "s1_acq";
        repeat (3) tick();
        rx_acq_phs = 12'h123;
        rx_acq_suc = 1'b1;
        tick();
        rx_acq_suc = 1'b0;
        tag = "s1_align";
        for (int p = 12'h118; p <= 12'h123; p++) begin
            rx_prn_phs = 12'(p);
            tick();
            if (p == 12'h122) check_val("s1_rst_before_match", longint'(tx_trk_rst), 1);
        end
        check_val("s1_rst_after_match", longint'(tx_trk_rst), 0);
        check_val("s1_state_pullin", longint'(tx_state), 3);

        // 2. Pull-in then lock with strong I.
        tag = "s2_pullin";
        rx_prn_phs = 12'h000;
        rx_acc_pi  = 24'(5000);
        rx_acc_pq  = 24'(100);
        rx_thr     = 24'(1000);
        for (int i = 0; i < PE; i++) send_sop();
        check_val("s2_track", longint'(tx_state), 4);
        tag = "s2_lock";
        n = 0;
        while (!tx_trk_lock && n < 100) begin
            send_sop();
            n++;
        end
        check_val("s2_sops_to_lock", n, LON);
        repeat (30) send_sop();

        // 3. Lose signal: lock falls at count 39, ACQ on the 64th bad epoch.
        tag = "s3_loss";
        rx_acc_pi = '0;
        n = 0;
        while (tx_trk_lock && n < 100) begin
            send_sop();
            n++;
        end
        check_val("s3_sops_to_unlock", n, 24);
        while (tx_state != 3'd1 && n < 200) begin
            send_sop();
            n++;
        end
        check_val("s3_sops_to_acq", n, 64);
        check_val("s3_acq_start", longint'(tx_acq_start), 1);

        // 5 + decision boundaries, each from an empty lock counter.
        tag = "s5_sat";
        enter_track();
        rx_acc_pi = 24'h800000;
        rx_acc_pq = '0;
        rx_thr    = 24'h7FFFFF;
        send_sop();
        check_val("s5_minneg_good", longint'(tx_state), 4);
        rx_acc_pi = '0;
        send_sop();
        check_val("s5_back_to_zero", longint'(tx_state), 4);
        send_sop();
        check_val("s5_drop_to_acq", longint'(tx_state), 1);

        tag = "tbl";
        for (int k = 0; k < 5; k++) begin
            enter_track();
            rx_acc_pi = 24'(tbl[k].pi);
            rx_acc_pq = 24'(tbl[k].pq);
            rx_thr    = 24'(tbl[k].thr);
            send_sop();
            check_val($sformatf("tbl%0d_decision", k), longint'(tx_state), tbl[k].good ? 4 : 1);
            if (tx_state == 3'd4) begin
                rx_acc_pi = '0;
                rx_thr    = 24'(1000);
                send_sop();
                send_sop();
            end
        end

        // 4. ALIGN timeout, then match on the final permitted cycle.
        tag = "s4_tmo";
        rx_acq_phs = 12'h555;
        rx_prn_phs = 12'h000;
        rx_acq_suc = 1'b1;
        tick();
        rx_acq_suc = 1'b0;
        n = 0;
        while (tx_state == 3'd2 && n < 40) begin
            tick();
            n++;
        end
        check_val("s4_align_cycles", n, TMO);
        check_val("s4_back_to_acq", longint'(tx_state), 1);
        rx_acq_suc = 1'b1;
        tick();
        rx_acq_suc = 1'b0;
        repeat (TMO - 1) tick();
        rx_prn_phs = 12'h555;
        tick();
        check_val("s4_match_last_cycle", longint'(tx_state), 3);

        // 6. Reset while locked.
        tag = "s6_lock";
        rx_acc_pi = 24'(5000);
        rx_acc_pq = 24'(100);
        rx_thr    = 24'(1000);
        repeat (PE + LON) send_sop();
        check_val("s6_locked", longint'(tx_trk_lock), 1);
        tag = "s6_rst";
        rx_rst = 1'b1;
        tick();
        rx_rst = 1'b0;
        check_val("s6_rst_trk_rst", longint'(tx_trk_rst), 1);
        check_val("s6_rst_lock", longint'(tx_trk_lock), 0);
        check_val("s6_rst_state", longint'(tx_state), 0);

        // Random traffic, including strobes/pulses in states that ignore them.
        tag = "rand";
        for (int c = 0; c < 1500; c++) begin
            int mag_i;
            rx_rst     = ($urandom_range(0, 499) == 0);
            rx_acq_suc = ($urandom_range(0, 9) == 0);
            rx_acq_phs = 12'($urandom_range(0, 7));
            rx_prn_phs = 12'($urandom_range(0, 7));
            rx_prn_sop = ($urandom_range(0, 2) == 0);
            mag_i      = ($urandom_range(0, 3) != 0) ? int'($urandom_range(3000, 8000))
                                                     : int'($urandom_range(0, 2000));
            rx_acc_pi  = 24'(($urandom_range(0, 1) != 0) ? mag_i : -mag_i);
            rx_acc_pq  = 24'(int'($urandom_range(0, 4000)) - 2000);
            rx_thr     = 24'($urandom_range(2000, 4000));
            tick();
        end
        rx_rst     = 1'b0;
        rx_prn_sop = 1'b0;
        rx_acq_suc = 1'b0;

        check_val("sb_empty", sb_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
